// File: rtl/weight_load_ctrl.sv
// ---------------------------------------------------------------------------
// weight_load_ctrl
//
// Loads the packed weight image into the encoder model's serial weight shift
// chain one bit per cycle (copy/k). Once every weight bit has shifted in, it
// hands the model over to inference traffic. No input vector can be accepted
// while the chain is partially loaded. y_valid marks the cycle in which the
// model's one-cycle output register holds the result of an accepted input.
//
// State table
//   state | meaning
//   IDLE  | after reset, chain contents undefined, nothing accepted
//   LOAD  | streaming weight words into the chain, inputs blocked
//   RUN   | chain fully loaded, inputs pass straight through to the model
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   load_start  in   one-cycle pulse, starts or restarts a weight load
//   w_valid     in   weight word valid
//   w_ready     out  weight word accepted when w_valid && w_ready
//   w_data      in   weight word, bit 0 shifted first
//   copy        out  shift enable for the model weight chain
//   k           out  serial weight bit for the model
//   loaded      out  all WEIGHTS_B bits have been shifted
//   busy        out  load in progress
//   x_valid     in   input vector valid (data goes directly to the model)
//   x_ready     out  input accepted when x_valid && x_ready
//   y_valid     out  model output register holds the last accepted input's result
//   inf_cnt     out  saturating count of accepted inputs since the last load
// ---------------------------------------------------------------------------
module weight_load_ctrl #(
    parameter int WEIGHTS_B = 10496,
    parameter int W         = 32,
    parameter int CNT_B     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [W-1:0]     w_data,
    output logic             copy,
    output logic             k,
    output logic             loaded,
    output logic             busy,
    input  logic             x_valid,
    output logic             x_ready,
    output logic             y_valid,
    output logic [CNT_B-1:0] inf_cnt
);

    localparam int N_WORDS = (WEIGHTS_B + W - 1) / W;
    localparam int BC_B    = $clog2(W + 1);
    localparam int BL_B    = $clog2(WEIGHTS_B + 1);
    localparam int WL_B    = $clog2(N_WORDS + 1);

    localparam logic [BC_B-1:0]  W_CNT     = BC_B'(W);
    localparam logic [BL_B-1:0]  W_AS_BITS = BL_B'(W);
    localparam logic [BL_B-1:0]  BITS_ALL  = BL_B'(WEIGHTS_B);
    localparam logic [WL_B-1:0]  WORDS_ALL = WL_B'(N_WORDS);
    localparam logic [CNT_B-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    shift_buf;
    logic [BC_B-1:0] buf_cnt;     // valid bits still waiting in shift_buf
    logic [BL_B-1:0] bits_left;   // chain bits not yet shifted
    logic [WL_B-1:0] words_left;  // words still to be fetched

    logic            w_accept;
    logic            x_accept;
    logic            last_bit;
    logic [BL_B-1:0] bits_after;
    logic [BC_B-1:0] fill_cnt;

    assign busy     = (state == LOAD);
    assign x_ready  = (state == RUN);
    assign copy     = busy && (buf_cnt != '0);
    assign k        = shift_buf[0];

    // Refill is allowed while the last buffered bit is shifting so a held-high
    // w_valid keeps copy continuous across word boundaries.
    assign w_ready  = busy && (words_left != '0) && (buf_cnt <= BC_B'(1)) && !load_start;
    assign w_accept = w_valid && w_ready;
    assign x_accept = x_valid && x_ready;
    assign last_bit = copy && (bits_left == BL_B'(1));

    // Only the bits the chain still needs are counted into the buffer, so the
    // padding of a partial final word is never shifted out.
    always_comb begin
        bits_after = bits_left - BL_B'(copy);
        if (bits_after >= W_AS_BITS) begin
            fill_cnt = W_CNT;
        end else begin
            fill_cnt = BC_B'(bits_after);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_buf  <= '0;
            buf_cnt    <= '0;
            bits_left  <= '0;
            words_left <= '0;
            loaded     <= 1'b0;
            y_valid    <= 1'b0;
            inf_cnt    <= '0;
        end else begin
            y_valid <= x_accept;

            // A coincident accept still pulses y_valid but does not survive the clear.
            if (load_start) begin
                inf_cnt <= '0;
            end else if (x_accept && (inf_cnt != CNT_MAX)) begin
                inf_cnt <= inf_cnt + CNT_B'(1);
            end

            if (load_start) begin
                state      <= LOAD;
                shift_buf  <= '0;
                buf_cnt    <= '0;
                bits_left  <= BITS_ALL;
                words_left <= WORDS_ALL;
                loaded     <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: begin
                        if (w_accept) begin
                            shift_buf  <= w_data;
                            buf_cnt    <= fill_cnt;
                            words_left <= words_left - WL_B'(1);
                        end else if (copy) begin
                            // Drop any padding left behind the final bit so it never reaches k.
                            shift_buf <= last_bit ? '0 : (shift_buf >> 1);
                            buf_cnt   <= buf_cnt - BC_B'(1);
                        end
                        if (copy) begin
                            bits_left <= bits_left - BL_B'(1);
                        end
                        if (last_bit) begin
                            state  <= RUN;
                            loaded <= 1'b1;
                        end
                    end
                    RUN: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/weight_load_ctrl.md
Name: weight_load_ctrl

Overview:
- Sequences the encoder model datapath: streams the packed weight image into the model's serial weight shift chain (copy/k), then gates inference traffic onto the model.
- Sits between the host-side weight stream / input source and the model instance. It guarantees that no input is presented while weights are partially loaded, and it marks when the one-cycle-registered model output is valid.

Parameters:
- WEIGHTS_B, 10496, total weight bits in the model shift chain.
- W, 32, width of an incoming weight word.
- CNT_B, 16, width of the inference counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse; begin (or restart) a weight load.
- w_valid  in  1  weight word valid.
- w_ready  out  1  weight word accepted when w_valid and w_ready are both high.
- w_data  in  W  weight word; bit 0 is shifted first.
- copy  out  1  shift enable to the model weight chain.
- k  out  1  serial weight bit to the model.
- loaded  out  1  high once all WEIGHTS_B bits have been shifted.
- busy  out  1  high in state LOAD.
- x_valid  in  1  input vector valid; data goes directly to model x.
- x_ready  out  1  input accepted when x_valid and x_ready are both high.
- y_valid  out  1  model y register holds the result of the accepted input.
- inf_cnt  out  CNT_B  count of accepted inputs.

Behaviour:
- State machine has three states: IDLE, LOAD, RUN.
  - IDLE -> LOAD on load_start.
  - LOAD -> RUN on the cycle after the final bit shifts.
  - RUN -> LOAD on load_start.
  - load_start in LOAD restarts the load: buffer and counters cleared, next state LOAD.
- Reset values: state IDLE; all outputs 0 (w_ready, copy, k, loaded, busy, x_ready, y_valid, inf_cnt).
- Internal registers in LOAD:
  - buf: W-bit shift buffer.
  - buf_cnt: bits remaining in buf.
  - bits_sent: 0..WEIGHTS_B.
  - words_left: starts at ceil(WEIGHTS_B/W).
- w_ready = LOAD && words_left>0 && (buf_cnt==0 || buf_cnt==1) && !load_start.
- On word accept:
  - buf <= w_data.
  - buf_cnt <= min(W, WEIGHTS_B - bits_sent - shifting_this_cycle).
  - words_left decrements.
  - Padding bits of the final word are never shifted.
- copy = LOAD && buf_cnt>0 (combinational from registers); k = buf[0].
- When copy is high: buf shifts right by one, buf_cnt and bits_sent increment/decrement accordingly.
- Bit ordering: the first bit shifted is weight bit 0, so after WEIGHTS_B shifts it lands in bit 0 of the chain. copy is high for exactly WEIGHTS_B cycles per completed load.
- Throughput and timing:
  - With w_valid held high, copy is continuous after a 1-cycle fill bubble (refill overlaps the last-bit shift).
  - load_start at cycle t: LOAD at t+1, first word accepted at t+1, copy high t+2 .. t+1+WEIGHTS_B, loaded=1 and RUN at t+2+WEIGHTS_B.
- Stalls: if w_valid is low while buf_cnt==0, copy=0 and the chain holds.
- loaded and busy:
  - loaded drops the cycle after load_start.
  - busy = (state==LOAD).
- Inference:
  - x_ready = (state==RUN).
  - An accept at cycle t gives y_valid=1 at t+1 only (single-cycle pulse).
  - Back-to-back accepts give y_valid high every cycle.
  - There is no output backpressure; y is overwritten each cycle.
- Simultaneous load_start and x accept in RUN: the input is accepted, y_valid still pulses at t+1 (computed on old weights, since copy is first asserted no earlier than t+2). x_ready is 0 from t+1.
- inf_cnt:
  - Increments on each x accept.
  - Saturates at 2^CNT_B-1.
  - Cleared by rst and by load_start.
- rst mid-load: returns to IDLE next cycle and copy drops immediately after the reset edge. Chain contents are undefined; a new load is required.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0; x_valid=1 in IDLE -> x_ready=0, y_valid stays 0.
- Continuous load, WEIGHTS_B=10496, W=32: load_start, 328 back-to-back words -> copy high exactly 10496 consecutive cycles; serialised k equals the concatenated image LSB-first; loaded=1 at t+10498.
- Stalled load: w_valid toggled randomly -> copy low during every bubble; total copy cycles = 10496; shadow chain model matches the image.
- Partial last word, WEIGHTS_B=40, W=32: 2 words accepted -> copy high 40 cycles; upper 24 bits of word 2 never appear on k; w_ready stays 0 after the 2nd word.
- Restart mid-load: load_start at bit 5000 -> counters reset; a full 10496-bit load follows and loaded rises only after it; inf_cnt=0.
- Inference: in RUN, 3 consecutive x accepts -> y_valid high 3 cycles starting 1 cycle later, inf_cnt=3. load_start coincident with the 3rd accept -> 3rd y_valid still fires and x_ready=0 next cycle.
